// File: rtl/ctrl_pkg.sv
// Shared encodings and the control bundle for the pipelined RV control unit.
// ctrl_t field order matches the datapath bundle: ALUSrc first, ALUOp last.
package ctrl_pkg;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADDI = 3'b000;
  localparam logic [2:0] F3_SLLI = 3'b001;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_RFN = 2'b10,
    ALU_SLT = 2'b11
  } alu_op_e;

  typedef struct packed {
    logic    alu_src;
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    memto_reg;
    logic    branch;
    logic    br_inv;
    logic    shift;
    alu_op_e alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/ctrl_decode.sv
// ID-stage decoder: opcode/funct3 to control bundle plus register-usage flags.
// Unsupported encodings yield CTRL_NOP so nothing downstream can fire.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter bit EXT_BRANCH = 1'b1
) (
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  output ctrl_t      ctrl,
  output logic       uses_rs1,
  output logic       uses_rs2,
  output logic       dec_illegal
);

  always_comb begin
    ctrl        = CTRL_NOP;
    uses_rs1    = 1'b0;
    uses_rs2    = 1'b0;
    dec_illegal = 1'b0;
    unique case (opcode)
      OP_IMM: begin
        if (funct3 == F3_ADDI || funct3 == F3_SLLI) begin
          ctrl.alu_src   = 1'b1;
          ctrl.reg_write = 1'b1;
          ctrl.shift     = (funct3 == F3_SLLI);
          ctrl.alu_op    = ALU_ADD;
          uses_rs1       = 1'b1;
        end else begin
          dec_illegal = 1'b1;
        end
      end
      OP_REG: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALU_RFN;
        uses_rs1       = 1'b1;
        uses_rs2       = 1'b1;
      end
      OP_LOAD: begin
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.mem_read  = 1'b1;
        ctrl.memto_reg = 1'b1;
        uses_rs1       = 1'b1;
      end
      OP_STORE: begin
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
        uses_rs1       = 1'b1;
        uses_rs2       = 1'b1;
      end
      OP_BRANCH: begin
        // bne/bge reuse the beq/blt compare with the outcome inverted
        if (funct3 == F3_BEQ || funct3 == F3_BLT ||
            (EXT_BRANCH && (funct3 == F3_BNE || funct3 == F3_BGE))) begin
          ctrl.branch = 1'b1;
          ctrl.br_inv = (funct3 == F3_BNE || funct3 == F3_BGE);
          ctrl.alu_op = (funct3 == F3_BLT || funct3 == F3_BGE) ? ALU_SLT : ALU_SUB;
          uses_rs1    = 1'b1;
          uses_rs2    = 1'b1;
        end else begin
          dec_illegal = 1'b1;
        end
      end
      default: dec_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ctrl_pipe_unit.sv
// Pipelined control unit: decode in ID, ID/EX, EX/MEM, MEM/WB control registers,
// load-use stall detection and EX-stage forwarding selects.
module ctrl_pipe_unit
  import ctrl_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter bit EXT_BRANCH = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [6:0]        opcode,
  input  logic [2:0]        funct3,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              flush,
  output logic              stall,
  output logic              illegal,
  output logic              ex_alu_src,
  output logic              ex_shift,
  output logic              ex_branch,
  output logic              ex_br_inv,
  output logic [1:0]        ex_alu_op,
  output logic [REG_AW-1:0] ex_rs1,
  output logic [REG_AW-1:0] ex_rs2,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              mem_mem_read,
  output logic              mem_mem_write,
  output logic              mem_branch,
  output logic              wb_reg_write,
  output logic              wb_memto_reg,
  output logic [REG_AW-1:0] wb_rd
);

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  ctrl_t dec_ctrl;
  logic  dec_uses_rs1;
  logic  dec_uses_rs2;
  logic  dec_illegal;

  ctrl_t             idex_ctrl;
  logic [REG_AW-1:0] idex_rd;
  logic [REG_AW-1:0] idex_rs1;
  logic [REG_AW-1:0] idex_rs2;

  logic              exmem_reg_write;
  logic              exmem_memto_reg;
  logic              exmem_mem_read;
  logic              exmem_mem_write;
  logic              exmem_branch;
  logic [REG_AW-1:0] exmem_rd;

  logic              memwb_reg_write;
  logic              memwb_memto_reg;
  logic [REG_AW-1:0] memwb_rd;

  logic hit_rs1;
  logic hit_rs2;
  logic idex_bubble;

  ctrl_decode #(
    .EXT_BRANCH(EXT_BRANCH)
  ) u_decode (
    .opcode     (opcode),
    .funct3     (funct3),
    .ctrl       (dec_ctrl),
    .uses_rs1   (dec_uses_rs1),
    .uses_rs2   (dec_uses_rs2),
    .dec_illegal(dec_illegal)
  );

  assign illegal = id_valid & dec_illegal;

  // Illegal encodings report no register usage, so they can never stall.
  assign hit_rs1 = dec_uses_rs1 && (idex_rd == id_rs1);
  assign hit_rs2 = dec_uses_rs2 && (idex_rd == id_rs2);
  assign stall   = id_valid && !flush && idex_ctrl.mem_read &&
                   (idex_rd != '0) && (hit_rs1 || hit_rs2);

  assign idex_bubble = flush || stall || !id_valid || illegal;

  always_ff @(posedge clk) begin
    if (reset) begin
      idex_ctrl       <= CTRL_NOP;
      idex_rd         <= '0;
      idex_rs1        <= '0;
      idex_rs2        <= '0;
      exmem_reg_write <= 1'b0;
      exmem_memto_reg <= 1'b0;
      exmem_mem_read  <= 1'b0;
      exmem_mem_write <= 1'b0;
      exmem_branch    <= 1'b0;
      exmem_rd        <= '0;
      memwb_reg_write <= 1'b0;
      memwb_memto_reg <= 1'b0;
      memwb_rd        <= '0;
    end else begin
      if (idex_bubble) begin
        idex_ctrl <= CTRL_NOP;
        idex_rd   <= '0;
        idex_rs1  <= '0;
        idex_rs2  <= '0;
      end else begin
        idex_ctrl <= dec_ctrl;
        idex_rd   <= id_rd;
        idex_rs1  <= id_rs1;
        idex_rs2  <= id_rs2;
      end
      exmem_reg_write <= idex_ctrl.reg_write;
      exmem_memto_reg <= idex_ctrl.memto_reg;
      exmem_mem_read  <= idex_ctrl.mem_read;
      exmem_mem_write <= idex_ctrl.mem_write;
      exmem_branch    <= idex_ctrl.branch;
      exmem_rd        <= idex_rd;
      memwb_reg_write <= exmem_reg_write;
      memwb_memto_reg <= exmem_memto_reg;
      memwb_rd        <= exmem_rd;
    end
  end

  // MEM is checked first so the youngest producer wins.
  always_comb begin
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
    if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == idex_rs1)) begin
      fwd_a = FWD_MEM;
    end else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == idex_rs1)) begin
      fwd_a = FWD_WB;
    end
    if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == idex_rs2)) begin
      fwd_b = FWD_MEM;
    end else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == idex_rs2)) begin
      fwd_b = FWD_WB;
    end
  end

  assign ex_alu_src    = idex_ctrl.alu_src;
  assign ex_shift      = idex_ctrl.shift;
  assign ex_branch     = idex_ctrl.branch;
  assign ex_br_inv     = idex_ctrl.br_inv;
  assign ex_alu_op     = idex_ctrl.alu_op;
  assign ex_rs1        = idex_rs1;
  assign ex_rs2        = idex_rs2;
  assign mem_mem_read  = exmem_mem_read;
  assign mem_mem_write = exmem_mem_write;
  assign mem_branch    = exmem_branch;
  assign wb_reg_write  = memwb_reg_write;
  assign wb_memto_reg  = memwb_memto_reg;
  assign wb_rd         = memwb_rd;

endmodule

// File: tb/tb_ctrl_pipe_unit.sv
// Directed bench for ctrl_pipe_unit; a second instance with EXT_BRANCH=0
// shares the same ID inputs to cover the bne/bge-illegal variant.
module tb_ctrl_pipe_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [4:0] id_rd, id_rs1, id_rs2;
  logic       flush;

  logic       stall, illegal;
  logic       ex_alu_src, ex_shift, ex_branch, ex_br_inv;
  logic [1:0] ex_alu_op;
  logic [4:0] ex_rs1, ex_rs2;
  logic [1:0] fwd_a, fwd_b;
  logic       mem_mem_read, mem_mem_write, mem_branch;
  logic       wb_reg_write, wb_memto_reg;
  logic [4:0] wb_rd;

  logic       n_stall, n_illegal;
  logic       n_ex_alu_src, n_ex_shift, n_ex_branch, n_ex_br_inv;
  logic [1:0] n_ex_alu_op;
  logic [4:0] n_ex_rs1, n_ex_rs2;
  logic [1:0] n_fwd_a, n_fwd_b;
  logic       n_mem_mem_read, n_mem_mem_write, n_mem_branch;
  logic       n_wb_reg_write, n_wb_memto_reg;
  logic [4:0] n_wb_rd;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  ctrl_pipe_unit #(.REG_AW(5), .EXT_BRANCH(1'b1)) u_dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .opcode(opcode), .funct3(funct3),
    .id_rd(id_rd), .id_rs1(id_rs1), .id_rs2(id_rs2), .flush(flush),
    .stall(stall), .illegal(illegal),
    .ex_alu_src(ex_alu_src), .ex_shift(ex_shift), .ex_branch(ex_branch),
    .ex_br_inv(ex_br_inv), .ex_alu_op(ex_alu_op), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .fwd_a(fwd_a), .fwd_b(fwd_b),
    .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write), .mem_branch(mem_branch),
    .wb_reg_write(wb_reg_write), .wb_memto_reg(wb_memto_reg), .wb_rd(wb_rd)
  );

  ctrl_pipe_unit #(.REG_AW(5), .EXT_BRANCH(1'b0)) u_dut_nx (
    .clk(clk), .reset(reset), .id_valid(id_valid), .opcode(opcode), .funct3(funct3),
    .id_rd(id_rd), .id_rs1(id_rs1), .id_rs2(id_rs2), .flush(flush),
    .stall(n_stall), .illegal(n_illegal),
    .ex_alu_src(n_ex_alu_src), .ex_shift(n_ex_shift), .ex_branch(n_ex_branch),
    .ex_br_inv(n_ex_br_inv), .ex_alu_op(n_ex_alu_op), .ex_rs1(n_ex_rs1), .ex_rs2(n_ex_rs2),
    .fwd_a(n_fwd_a), .fwd_b(n_fwd_b),
    .mem_mem_read(n_mem_mem_read), .mem_mem_write(n_mem_mem_write), .mem_branch(n_mem_branch),
    .wb_reg_write(n_wb_reg_write), .wb_memto_reg(n_wb_memto_reg), .wb_rd(n_wb_rd)
  );

  logic [5:0]  ex_bits;
  logic [2:0]  mem_bits;
  logic [1:0]  wb_bits;
  logic [31:0] all_outs;
  assign ex_bits  = {ex_alu_src, ex_shift, ex_branch, ex_br_inv, ex_alu_op};
  assign mem_bits = {mem_mem_read, mem_mem_write, mem_branch};
  assign wb_bits  = {wb_reg_write, wb_memto_reg};
  assign all_outs = {ex_bits, ex_rs1, ex_rs2, fwd_a, fwd_b, mem_bits, wb_bits, wb_rd,
                     stall, illegal};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
  endtask

  task automatic issue(input logic v, input logic [6:0] op, input logic [2:0] f3,
                       input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic fl);
    id_valid = v; opcode = op; funct3 = f3;
    id_rd = rd; id_rs1 = rs1; id_rs2 = rs2; flush = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    issue(1'b0, 7'd0, 3'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    repeat (3) tick();
  endtask

  // sweep order: addi slli R ld sd beq blt bne bge
  logic [6:0] sw_op  [9];
  logic [2:0] sw_f3  [9];
  logic [5:0] sw_ex  [9];
  logic [2:0] sw_mem [9];
  logic [1:0] sw_wb  [9];

  initial begin
    sw_op  = '{7'b0010011, 7'b0010011, 7'b0110011, 7'b0000011, 7'b0100011,
               7'b1100011, 7'b1100011, 7'b1100011, 7'b1100011};
    sw_f3  = '{3'b000, 3'b001, 3'b000, 3'b110, 3'b111, 3'b000, 3'b100, 3'b001, 3'b101};
    sw_ex  = '{6'b100000, 6'b110000, 6'b000010, 6'b100000, 6'b100000,
               6'b001001, 6'b001011, 6'b001101, 6'b001111};
    sw_mem = '{3'b000, 3'b000, 3'b000, 3'b100, 3'b010, 3'b001, 3'b001, 3'b001, 3'b001};
    sw_wb  = '{2'b10, 2'b10, 2'b10, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};

    reset = 1'b1;
    issue(1'b0, 7'd0, 3'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    repeat (2) tick();
    chk("reset_all", all_outs, 32'd0);
    reset = 1'b0;
    tick();
    chk("idle_all", all_outs, 32'd0);

    for (int i = 0; i < 9; i++) begin
      issue(1'b1, sw_op[i], sw_f3[i], 5'd5, 5'd1, 5'd2, 1'b0);
      #1;
      chk("sweep_illegal", {31'd0, illegal}, 32'd0);
      tick();
      chk("sweep_ex", {26'd0, ex_bits}, {26'd0, sw_ex[i]});
      chk("sweep_mem", {29'd0, mem_bits}, (i >= 1) ? {29'd0, sw_mem[i-1]} : 32'd0);
      chk("sweep_wb", {30'd0, wb_bits}, (i >= 2) ? {30'd0, sw_wb[i-2]} : 32'd0);
      if (i >= 2 && sw_wb[i-2][1]) chk("sweep_wb_rd", {27'd0, wb_rd}, 32'd5);
    end
    drain();

    // load-use: ld x3 ; add x4,x3,x1
    issue(1'b1, 7'b0000011, 3'b011, 5'd3, 5'd1, 5'd2, 1'b0);
    tick();
    issue(1'b1, 7'b0110011, 3'b000, 5'd4, 5'd3, 5'd1, 1'b0);
    #1;
    chk("lu_stall", {31'd0, stall}, 32'd1);
    tick();
    chk("lu_bubble", {16'd0, ex_bits, ex_rs1, ex_rs2}, 32'd0);
    chk("lu_stall_once", {31'd0, stall}, 32'd0);
    tick();
    chk("lu_add_ex", {30'd0, ex_alu_op}, 32'd2);
    chk("lu_fwd_a", {30'd0, fwd_a}, 32'b01);
    chk("lu_fwd_b", {30'd0, fwd_b}, 32'b00);
    drain();

    // EX/MEM forward: addi x2 ; add x5,x2,x2
    issue(1'b1, 7'b0010011, 3'b000, 5'd2, 5'd1, 5'd0, 1'b0);
    tick();
    issue(1'b1, 7'b0110011, 3'b000, 5'd5, 5'd2, 5'd2, 1'b0);
    tick();
    chk("fwd_mem", {28'd0, fwd_a, fwd_b}, 32'b1010);
    drain();

    // MEM/WB forward with a nop between
    issue(1'b1, 7'b0010011, 3'b000, 5'd2, 5'd1, 5'd0, 1'b0);
    tick();
    issue(1'b0, 7'd0, 3'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    tick();
    issue(1'b1, 7'b0110011, 3'b000, 5'd5, 5'd2, 5'd2, 1'b0);
    tick();
    chk("fwd_wb", {28'd0, fwd_a, fwd_b}, 32'b0101);
    drain();

    // both stages write x2: MEM wins
    issue(1'b1, 7'b0010011, 3'b000, 5'd2, 5'd1, 5'd0, 1'b0);
    tick();
    issue(1'b1, 7'b0010011, 3'b000, 5'd2, 5'd1, 5'd0, 1'b0);
    tick();
    issue(1'b1, 7'b0110011, 3'b000, 5'd5, 5'd2, 5'd2, 1'b0);
    tick();
    chk("fwd_prio", {28'd0, fwd_a, fwd_b}, 32'b1010);
    drain();

    // x0: ld x0 ; add x1,x0,x0
    issue(1'b1, 7'b0000011, 3'b011, 5'd0, 5'd1, 5'd0, 1'b0);
    tick();
    issue(1'b1, 7'b0110011, 3'b000, 5'd1, 5'd0, 5'd0, 1'b0);
    #1;
    chk("x0_stall", {31'd0, stall}, 32'd0);
    tick();
    chk("x0_add_ex", {30'd0, ex_alu_op}, 32'd2);
    chk("x0_fwd", {28'd0, fwd_a, fwd_b}, 32'd0);
    drain();

    // flush and stall together: ld x3 ; beq x3,x1 with flush
    issue(1'b1, 7'b0000011, 3'b011, 5'd3, 5'd1, 5'd0, 1'b0);
    tick();
    issue(1'b1, 7'b1100011, 3'b000, 5'd0, 5'd3, 5'd1, 1'b0);
    #1;
    chk("fl_stall_noflush", {31'd0, stall}, 32'd1);
    flush = 1'b1;
    #1;
    chk("fl_stall_forced0", {31'd0, stall}, 32'd0);
    tick();
    issue(1'b0, 7'd0, 3'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    chk("fl_bubble", {16'd0, ex_bits, ex_rs1, ex_rs2}, 32'd0);
    tick();
    chk("fl_mem_branch", {31'd0, mem_branch}, 32'd0);
    drain();

    // illegal encoding
    issue(1'b1, 7'b1111111, 3'b000, 5'd5, 5'd1, 5'd2, 1'b0);
    #1;
    chk("ill_flag", {31'd0, illegal}, 32'd1);
    tick();
    chk("ill_bubble", {16'd0, ex_bits, ex_rs1, ex_rs2}, 32'd0);
    issue(1'b0, 7'b1111111, 3'b000, 5'd5, 5'd1, 5'd2, 1'b0);
    #1;
    chk("ill_novalid", {31'd0, illegal}, 32'd0);

    // bne with and without the branch extension
    issue(1'b1, 7'b1100011, 3'b001, 5'd0, 5'd1, 5'd2, 1'b0);
    #1;
    chk("bne_ext_legal", {31'd0, illegal}, 32'd0);
    chk("bne_noext_illegal", {31'd0, n_illegal}, 32'd1);
    tick();
    chk("bne_ext_inv", {31'd0, ex_br_inv}, 32'd1);
    chk("bne_noext_bubble", {30'd0, n_ex_branch, n_ex_br_inv}, 32'd0);
    drain();

    // reset mid-stream
    issue(1'b1, 7'b0010011, 3'b000, 5'd2, 5'd1, 5'd0, 1'b0);
    tick();
    issue(1'b1, 7'b0000011, 3'b011, 5'd3, 5'd1, 5'd0, 1'b0);
    tick();
    issue(1'b1, 7'b0110011, 3'b000, 5'd4, 5'd6, 5'd7, 1'b0);
    tick();
    chk("pre_rst_wb", {27'd0, wb_reg_write, wb_rd}, {27'd0, 1'b1, 5'd2});
    reset = 1'b1;
    issue(1'b0, 7'd0, 3'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    tick();
    chk("mid_rst_all", all_outs, 32'd0);
    reset = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe_unit.md
# ctrl_pipe_unit

Pipelined control unit for the 5-stage RV core. It decodes opcode/funct3 in ID and carries the control bundle through the ID/EX, EX/MEM and MEM/WB registers. It also detects load-use hazards (stall plus bubble) and generates EX-stage forwarding selects. Unlike the earlier purely combinational decoder, illegal encodings decode to a safe all-zero bundle with an `illegal` flag, and optional `bne`/`bge` support is selected by parameter.

## Interface
- `REG_AW`, default 5: register-index width.
- `EXT_BRANCH`, default 1: 1 adds `bne`/`bge` decode; 0 treats them as illegal.
- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high; clears all pipeline control registers.
- `id_valid` in 1: the ID-stage instruction is real (0 = bubble).
- `opcode` in 7, `funct3` in 3: ID-stage instruction fields.
- `id_rd`, `id_rs1`, `id_rs2` in REG_AW: ID-stage register indices.
- `flush` in 1: branch taken; squash the ID-stage instruction.
- `stall` out 1: combinational load-use hazard; holds the PC and IF/ID register.
- `illegal` out 1: combinational; `id_valid` is high and the encoding is unsupported.
- `ex_alu_src`, `ex_shift`, `ex_branch`, `ex_br_inv` out 1 each; `ex_alu_op` out 2: EX controls.
- `ex_rs1`, `ex_rs2` out REG_AW: EX operand indices.
- `fwd_a`, `fwd_b` out 2: forwarding selects. 00 = register file, 10 = EX/MEM result, 01 = MEM/WB result.
- `mem_mem_read`, `mem_mem_write`, `mem_branch` out 1 each: MEM controls.
- `wb_reg_write`, `wb_memto_reg` out 1 each; `wb_rd` out REG_AW: WB controls.

## Operation
- Decode, in the bundle order ALUSrc, RegWrite, MemRead, MemWrite, MemtoReg, Branch, BrInv, Shift, ALUOp:
  - `addi` (0010011/000): 1,1,0,0,0,0,0,0,00.
  - `slli` (0010011/001): same as `addi` with Shift=1.
  - R-type (0110011): 0,1,0,0,0,0,0,0,10.
  - `ld` (0000011): 1,1,1,0,1,0,0,0,00.
  - `sd` (0100011): 1,0,0,1,0,0,0,0,00.
  - `beq` (1100011/000): 0,0,0,0,0,1,0,0,01.
  - `blt` (1100011/100): same as `beq` with ALUOp=11.
  - `bne` (001) and `bge` (101), only when EXT_BRANCH=1: same as `beq`/`blt` with BrInv=1.
  - `ld` and `sd` ignore funct3.
- Any other encoding decodes to the all-zero bundle; `illegal` is raised if `id_valid` is high.
- Register usage: rs1 is used by every legal instruction. rs2 is used by R-type, `sd` and branches.
- Load-use hazard: `stall` = ID/EX.MemRead AND ex_rd≠0 AND ((uses_rs1 AND ex_rd==id_rs1) OR (uses_rs2 AND ex_rd==id_rs2)), gated by `id_valid` and by `!flush`.
- ID/EX load value:
  - A bubble (all controls zero, indices zero) if `reset`, `flush`, `stall`, `!id_valid` or `illegal`.
  - Otherwise the decoded bundle plus `id_rd`/`id_rs1`/`id_rs2`.
- EX/MEM and MEM/WB always advance; they carry the relevant control subset and rd.
- Forwarding, for `fwd_a` (`fwd_b` identical using `ex_rs2`):
  - 10 if mem RegWrite and mem_rd≠0 and mem_rd==ex_rs1.
  - Else 01 if wb RegWrite and wb_rd≠0 and wb_rd==ex_rs1.
  - Else 00.
  - When both match, MEM has priority.

## Timing
- Reset value of every registered output is 0. `stall`, `illegal` and `fwd_*` are 0 while the pipeline holds bubbles.
- Latency from ID inputs: EX outputs +1 cycle, MEM outputs +2, WB outputs +3.
- `stall` is asserted in the same cycle the hazard is present. It stays high for exactly one cycle per load-use pair, because the load then moves to MEM.
- Simultaneous `flush` and `stall`: `flush` wins. A bubble enters ID/EX and `stall` is forced to 0.
- `reset` mid-stream: the next edge zeroes all three stage registers; in-flight writes are discarded.
- Destination x0 never causes a stall or a forward.

## Structure
- Package `ctrl_pkg` holds:
  - Opcode and funct3 localparams.
  - ALUOp encodings (00 add, 01 sub/eq, 10 R-funct, 11 slt).
  - A packed `ctrl_t` bundle typedef and the `CTRL_NOP` constant.
- One combinational sub-module, `ctrl_decode` (opcode, funct3, EXT_BRANCH → `ctrl_t`, `uses_rs1`, `uses_rs2`, `illegal`).
- Hazard detection, forwarding and the stage registers live in the top level.

## Test plan
- Decode sweep: each legal op with rd=5. Expect the tabled bundle on the EX outputs one cycle later. `wb_reg_write`=1, `wb_rd`=5 three cycles later for `addi`/`ld`/R-type.
- Load-use: `ld x3` followed by `add x4,x3,x1`. Expect `stall`=1 for one cycle, a bubble in EX, then `add` in EX with `fwd_a`=01.
- Forwarding: `addi x2` then `add x5,x2,x2`. Expect `fwd_a`=`fwd_b`=10. With a nop inserted between them, expect 01. With both stages writing x2, expect 10.
- x0: `ld x0` then `add x1,x0,x0`. Expect no stall and `fwd`=00.
- Flush and stall in the same cycle: expect `stall`=0, ID/EX bubble, `mem_branch`=0 two cycles later.
- Illegal and ext: opcode 1111111 gives `illegal`=1 and an all-zero bundle. `bne` gives `ex_br_inv`=1 with EXT_BRANCH=1, and `illegal`=1 with EXT_BRANCH=0. Reset asserted mid-sequence zeroes all outputs after one edge.
